// File: rtl/adiabatic_pkg.sv
// rtl/adiabatic_pkg.sv - shared types and width helper for the adiabatic phase sequencer
package adiabatic_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  typedef enum logic [1:0] {Q_RISE, Q_HOLD, Q_FALL, Q_WAIT} quarter_e;

  // DAC code spans 0..STEPS inclusive
  function automatic int calc_cw(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/adiabatic_phase_decode.sv
// rtl/adiabatic_phase_decode.sv - per-phase trapezoid decode of the master counter
module adiabatic_phase_decode
  import adiabatic_pkg::*;
#(
  parameter int STEPS   = 8,
  parameter int N_PHASE = 4,
  localparam int P      = 4 * STEPS,
  localparam int MW     = $clog2(P),
  localparam int KW     = $clog2(N_PHASE),
  localparam int CW     = calc_cw(STEPS)
) (
  input  logic [MW-1:0] m,
  input  logic [KW-1:0] k,
  input  logic          active,
  output logic [CW-1:0] code,
  output logic          rise,
  output logic          hold,
  output logic          fall
);

  logic [31:0] offset;
  logic [31:0] t;
  logic [31:0] s;
  quarter_e    q;

  always_comb begin
    // local time lags the master counter by k quarters, modulo the period
    offset = (32'(k) * 32'(STEPS)) % 32'(P);
    t      = (32'(m) >= offset) ? (32'(m) - offset) : (32'(m) + 32'(P) - offset);
    s      = t % 32'(STEPS);
    q      = quarter_e'(2'(t / 32'(STEPS)));
    code   = '0;
    rise   = 1'b0;
    hold   = 1'b0;
    fall   = 1'b0;
    if (active) begin
      case (q)
        Q_RISE: begin
          code = CW'(s + 32'd1);
          rise = 1'b1;
        end
        Q_HOLD: begin
          code = CW'(STEPS);
          hold = 1'b1;
        end
        Q_FALL: begin
          code = CW'(32'(STEPS) - 32'd1 - s);
          fall = 1'b1;
        end
        default: code = '0;
      endcase
    end
  end

endmodule

// File: rtl/adiabatic_phase_sequencer.sv
// rtl/adiabatic_phase_sequencer.sv - start-up/run/drain control of multi-phase power clocks
module adiabatic_phase_sequencer
  import adiabatic_pkg::*;
#(
  parameter int  N_PHASE = 4,
  parameter int  STEPS   = 8,
  localparam int CW      = calc_cw(STEPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic [N_PHASE*CW-1:0] phase_code,
  output logic [N_PHASE-1:0]    phase_rise,
  output logic [N_PHASE-1:0]    phase_hold,
  output logic [N_PHASE-1:0]    phase_fall
);

  localparam int P  = 4 * STEPS;
  localparam int MW = $clog2(P);
  localparam int KW = $clog2(N_PHASE);

  state_e              state, state_nxt;
  logic [MW-1:0]       m, m_nxt, m_inc;
  logic [N_PHASE-1:0]  active, active_nxt;
  logic                done_q, done_nxt;
  logic [N_PHASE-1:0]  last_fall;
  logic [N_PHASE-1:0]  pred_on;

  for (genvar k = 0; k < N_PHASE; k++) begin : g_phase
    adiabatic_phase_decode #(
      .STEPS   (STEPS),
      .N_PHASE (N_PHASE)
    ) u_decode (
      .m      (m),
      .k      (KW'(k)),
      .active (active[k]),
      .code   (phase_code[k*CW +: CW]),
      .rise   (phase_rise[k]),
      .hold   (phase_hold[k]),
      .fall   (phase_fall[k])
    );
    // a falling phase shows code 0 only on its final ramp-down step
    assign last_fall[k] = phase_fall[k] && (phase_code[k*CW +: CW] == '0);
  end

  // bit k set when phase k has an active predecessor; phase 0 has none
  assign pred_on = {active[N_PHASE-2:0], 1'b0};
  assign m_inc   = (m == MW'(P - 1)) ? '0 : m + 1'b1;

  always_comb begin
    state_nxt  = state;
    m_nxt      = m;
    active_nxt = active;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = RUN;
          m_nxt      = '0;
          active_nxt = N_PHASE'(1);
        end
      end
      RUN: begin
        m_nxt = m_inc;
        for (int k = 1; k < N_PHASE; k++) begin
          if (pred_on[k] && (32'(m) == 32'(k * STEPS - 1))) active_nxt[k] = 1'b1;
        end
        if (stop) state_nxt = DRAIN;
      end
      DRAIN: begin
        m_nxt = m_inc;
        for (int k = 0; k < N_PHASE; k++) begin
          if (last_fall[k] && !pred_on[k]) active_nxt[k] = 1'b0;
        end
        if (active_nxt == '0) begin
          state_nxt = IDLE;
          m_nxt     = '0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      m      <= '0;
      active <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      m      <= m_nxt;
      active <= active_nxt;
      done_q <= done_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;

endmodule
